// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic ops, iterative shift-add multiply and iterative shifts.
// Operands are latched on an accepted START; DONE pulses when the registered outputs update.
`timescale 1ns/1ps

module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StMul   = 2'd1;
    localparam logic [1:0] StShift = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] mlr_next;
    logic [WIDTH-1:0] shift_next;

    // FORWARD passes operand 2; a zero-amount shift falls to the default and passes operand 1.
    always_comb begin
        case (op_q)
            3'b000:  alu_res = opb_q;
            3'b001:  alu_res = opa_q + opb_q;
            3'b010:  alu_res = opa_q & opb_q;
            3'b011:  alu_res = opa_q | opb_q;
            default: alu_res = opa_q;
        endcase
    end

    // One shift-add step: the sum keeps its carry in the extra accumulator bit.
    always_comb begin
        mul_sum  = acc_q + (opb_q[0] ? {1'b0, opa_q} : '0);
        acc_next = {1'b0, mul_sum[WIDTH:1]};
        mlr_next = {mul_sum[0], opb_q[WIDTH-1:1]};
    end

    always_comb begin
        case (op_q[1:0])
            2'b01:   shift_next = {opa_q[WIDTH-2:0], 1'b0};
            2'b10:   shift_next = {1'b0, opa_q[WIDTH-1:1]};
            2'b11:   shift_next = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
            default: shift_next = opa_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (busy_q) begin
                    result_d    = alu_res;
                    result_hi_d = '0;
                    zero_d      = (alu_res == '0);
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                end else if (START) begin
                    op_d   = SELECT;
                    opa_d  = DATA1;
                    opb_d  = DATA2;
                    busy_d = 1'b1;
                    if (SELECT == 3'b100) begin
                        state_d = StMul;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else if (SELECT[2] && (DATA2[SHW-1:0] != '0)) begin
                        state_d = StShift;
                        cnt_d   = DATA2[SHW-1:0];
                    end
                end
            end
            StMul: begin
                acc_d = acc_next;
                opb_d = mlr_next;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    result_d    = mlr_next;
                    result_hi_d = acc_next[WIDTH-1:0];
                    zero_d      = (mlr_next == '0);
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            StShift: begin
                opa_d = shift_next;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d    = shift_next;
                    result_hi_d = '0;
                    zero_d      = (shift_next == '0);
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign RESULT    = result_q;
    assign RESULT_HI = result_hi_q;
    assign ZERO      = zero_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed literal cases plus random traffic
// compared every cycle against a transaction-level latency/result model.
`timescale 1ns/1ps

module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   sel = 3'b000;
    logic [W-1:0] d1 = '0;
    logic [W-1:0] d2 = '0;
    logic [W-1:0] result, result_hi;
    logic         zero, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: outputs plus a countdown to completion of the pending op.
    logic [W-1:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
    logic         m_zero = 1'b1, m_busy = 1'b0, m_done = 1'b0;
    int           m_cnt = 0;

    seq_alu #(.WIDTH(W)) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .START     (start),
        .SELECT    (sel),
        .DATA1     (d1),
        .DATA2     (d2),
        .RESULT    (result),
        .RESULT_HI (result_hi),
        .ZERO      (zero),
        .BUSY      (busy),
        .DONE      (done)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        logic [2*W-1:0] prod;
        int amt;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_lo = '0; m_hi = '0; m_zero = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_lo = p_lo; m_hi = p_hi; m_zero = (p_lo == 0);
                    m_done = 1'b1; m_busy = 1'b0;
                end
            end else if (start) begin
                amt  = int'(d2 % W);
                prod = {{W{1'b0}}, d1} * {{W{1'b0}}, d2};
                p_hi = '0;
                m_cnt = 1;
                case (sel)
                    3'd0: p_lo = d2;
                    3'd1: p_lo = d1 + d2;
                    3'd2: p_lo = d1 & d2;
                    3'd3: p_lo = d1 | d2;
                    3'd4: begin p_lo = prod[W-1:0]; p_hi = prod[2*W-1:W]; m_cnt = W; end
                    3'd5: p_lo = d1 << amt;
                    3'd6: p_lo = d1 >> amt;
                    default: p_lo = $signed(d1) >>> amt;
                endcase
                if (sel >= 3'd5 && amt != 0) m_cnt = amt;
                m_busy = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cyc RESULT", 32'(result), 32'(m_lo));
        chk("cyc RESULT_HI", 32'(result_hi), 32'(m_hi));
        chk("cyc ZERO", 32'(zero), 32'(m_zero));
        chk("cyc BUSY", 32'(busy), 32'(m_busy));
        chk("cyc DONE", 32'(done), 32'(m_done));
    end

    task automatic run_op(input string nm, input logic [2:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] elo,
                          input logic [W-1:0] ehi, input logic ez, input int elat);
        int lat;
        @(negedge clk);
        start = 1'b1; sel = s; d1 = a; d2 = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; sel = 3'($urandom); d1 = W'($urandom); d2 = W'($urandom);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " RESULT"}, 32'(result), 32'(elo));
        chk({nm, " RESULT_HI"}, 32'(result_hi), 32'(ehi));
        chk({nm, " ZERO"}, 32'(zero), 32'(ez));
        @(negedge clk);
        chk({nm, " DONE drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int saw_done;
        #23;
        chk("reset RESULT", 32'(result), 32'h0);
        chk("reset ZERO", 32'(zero), 32'h1);
        chk("reset BUSY", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("ADD 05+FB", 3'd1, 8'h05, 8'hFB, 8'h00, 8'h00, 1'b1, 1);
        run_op("MUL 13x11", 3'd4, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0, 8);
        run_op("MUL FFxFF", 3'd4, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 8);
        run_op("SRA 90>>>3", 3'd7, 8'h90, 8'h03, 8'hF2, 8'h00, 1'b0, 3);
        run_op("SRL 90>>3", 3'd6, 8'h90, 8'h03, 8'h12, 8'h00, 1'b0, 3);
        run_op("SLL 90<<0", 3'd5, 8'h90, 8'h00, 8'h90, 8'h00, 1'b0, 1);
        run_op("FWD", 3'd0, 8'h3C, 8'hA5, 8'hA5, 8'h00, 1'b0, 1);
        run_op("AND", 3'd2, 8'hC3, 8'h5A, 8'h42, 8'h00, 1'b0, 1);
        run_op("OR", 3'd3, 8'hC3, 8'h5A, 8'hDB, 8'h00, 1'b0, 1);

        // An ADD request while a multiply is busy must be dropped.
        @(negedge clk);
        start = 1'b1; sel = 3'd4; d1 = 8'd13; d2 = 8'd11;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin start = 1'b1; sel = 3'd1; d1 = 8'h01; d2 = 8'h01; end
            else if (lat == 3) start = 1'b0;
        end
        chk("ignore latency", 32'(lat), 32'd8);
        chk("ignore RESULT", 32'(result), 32'h8F);
        @(negedge clk);
        chk("ignore no 2nd op BUSY", 32'(busy), 32'd0);
        chk("ignore no 2nd op DONE", 32'(done), 32'd0);

        // Asynchronous reset partway through a multiply.
        @(negedge clk);
        start = 1'b1; sel = 3'd4; d1 = 8'hFF; d2 = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst RESULT", 32'(result), 32'h0);
        chk("midrst RESULT_HI", 32'(result_hi), 32'h0);
        chk("midrst ZERO", 32'(zero), 32'h1);
        chk("midrst BUSY", 32'(busy), 32'h0);
        chk("midrst DONE", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("midrst no DONE", 32'(saw_done), 32'd0);
        run_op("MUL after rst", 3'd4, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0, 8);

        // Random traffic, including START held across busy periods and back-to-back issue.
        repeat (1500) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            sel   = 3'($urandom);
            d1    = W'($urandom);
            d2    = W'($urandom);
            if ($urandom_range(0, 7) == 0) d2 = -d1;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
